scurve_channel_counter: RTL and testbench

- Per-channel S-curve measurement engine; sits directly upstream of the S-curve data FIFO and is started by the S-curve test controller once per channel/DAC point.
- Counts CPT_MAX charge-injection pulses on CLK_EXT.
- Per injection, records whether each of the three Microroc trigger outputs fired.
- Then writes a 5-word result frame into the FIFO and pulses One_Channel_Done.

---
 rtl/scurve_channel_counter_pkg.sv | 48 ++++
 rtl/scurve_edge_sync.sv | 35 +++
 rtl/scurve_channel_counter.sv | 166 ++++++++++++++++
 tb/tb_scurve_channel_counter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/scurve_channel_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scurve_channel_counter_pkg
// Description : Shared types and constants for the S-curve channel counter.
// Revision    : 1.0 - initial release
// ============================================================================
package scurve_channel_counter_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_TAIL  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int          c_NUM_TRIG             = 3;
    localparam logic [2:0]  c_FRAME_LEN            = 3'd5;
    localparam logic [2:0]  c_IDX_HEADER           = 3'd0;
    localparam logic [2:0]  c_IDX_PULSE            = 3'd1;
    localparam logic [2:0]  c_IDX_TRIG0            = 3'd2;
    localparam logic [2:0]  c_IDX_TRIG1            = 3'd3;
    localparam logic [2:0]  c_IDX_TRIG2            = 3'd4;
    localparam logic [15:0] c_FRAME_HEADER_DEFAULT = 16'hFF45;

    function automatic logic [15:0] frame_word(
        input logic [2:0]  idx,
        input logic [15:0] header,
        input logic [15:0] pulse_cnt,
        input logic [15:0] trig0_cnt,
        input logic [15:0] trig1_cnt,
        input logic [15:0] trig2_cnt
    );
        logic [15:0] word;
        word = 16'h0000;
        case (idx)
            c_IDX_HEADER: word = header;
            c_IDX_PULSE:  word = pulse_cnt;
            c_IDX_TRIG0:  word = trig0_cnt;
            c_IDX_TRIG1:  word = trig1_cnt;
            c_IDX_TRIG2:  word = trig2_cnt;
            default:      word = 16'h0000;
        endcase
        return word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scurve_edge_sync.sv
`default_nettype none
// ============================================================================
// Module      : scurve_edge_sync
// Description : Multi-flop synchroniser followed by a one-cycle edge pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module scurve_edge_sync #(
    parameter int   SYNC_STAGES = 2,     // must be >= 2
    parameter logic DETECT_FALL = 1'b0   // 0: rising-edge pulse, 1: falling-edge pulse
) (
    input  logic Clk,
    input  logic reset_n,
    input  logic i_async,
    output logic o_edge
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   w_cur;

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_cur  = r_sync[SYNC_STAGES-1];
    assign o_edge = DETECT_FALL ? (~w_cur & r_prev) : (w_cur & ~r_prev);

endmodule
`default_nettype wire

// File: rtl/scurve_channel_counter.sv
`default_nettype none
// ============================================================================
// Module      : scurve_channel_counter
// Description : Counts injections and per-window trigger hits, then emits a
//               five-word result frame to the S-curve FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module scurve_channel_counter
    import scurve_channel_counter_pkg::*;
#(
    parameter int          SYNC_STAGES  = 2,
    parameter int          TAIL_CYCLES  = 64,
    parameter logic [15:0] FRAME_HEADER = c_FRAME_HEADER_DEFAULT
) (
    input  logic        Clk,
    input  logic        reset_n,
    input  logic        SCurve_Test_Start,
    input  logic [15:0] CPT_MAX,
    input  logic        CLK_EXT,
    input  logic        out_trigger0b,
    input  logic        out_trigger1b,
    input  logic        out_trigger2b,
    output logic [15:0] SCurve_Data,
    output logic        SCurve_Data_wr_en,
    output logic        One_Channel_Done
);

    localparam int                   c_TIMER_W   = $clog2(TAIL_CYCLES + 1);
    localparam logic [c_TIMER_W-1:0] c_TAIL_LOAD = c_TIMER_W'(TAIL_CYCLES - 1);

    state_t                 r_state;
    logic [15:0]            r_cpt_max;
    logic [15:0]            r_pulse_cnt;
    logic [15:0]            r_trig_cnt [c_NUM_TRIG];
    logic [c_NUM_TRIG-1:0]  r_hit;
    logic [c_TIMER_W-1:0]   r_tail_timer;
    logic [2:0]             r_word_idx;

    logic                   w_inject;
    logic [c_NUM_TRIG-1:0]  w_trig_b;
    logic [c_NUM_TRIG-1:0]  w_hit_edge;
    logic                   w_last_pulse;

    scurve_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .DETECT_FALL (1'b0)
    ) u_inject_sync (
        .Clk     (Clk),
        .reset_n (reset_n),
        .i_async (CLK_EXT),
        .o_edge  (w_inject)
    );

    assign w_trig_b = {out_trigger2b, out_trigger1b, out_trigger0b};

    // Triggers are active-low, so a hit is the synchronised 1->0 transition.
    for (genvar gi = 0; gi < c_NUM_TRIG; gi++) begin : g_trig_sync
        scurve_edge_sync #(
            .SYNC_STAGES (SYNC_STAGES),
            .DETECT_FALL (1'b1)
        ) u_trig_sync (
            .Clk     (Clk),
            .reset_n (reset_n),
            .i_async (w_trig_b[gi]),
            .o_edge  (w_hit_edge[gi])
        );
    end

    assign w_last_pulse = ((r_pulse_cnt + 16'd1) == r_cpt_max);

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state           <= S_IDLE;
            r_cpt_max         <= 16'd0;
            r_pulse_cnt       <= 16'd0;
            r_hit             <= '0;
            r_tail_timer      <= '0;
            r_word_idx        <= 3'd0;
            SCurve_Data       <= 16'd0;
            SCurve_Data_wr_en <= 1'b0;
            One_Channel_Done  <= 1'b0;
            for (int i = 0; i < c_NUM_TRIG; i++) begin
                r_trig_cnt[i] <= 16'd0;
            end
        end else begin
            SCurve_Data_wr_en <= 1'b0;
            One_Channel_Done  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (SCurve_Test_Start) begin
                        r_cpt_max   <= CPT_MAX;
                        r_pulse_cnt <= 16'd0;
                        r_hit       <= '0;
                        for (int i = 0; i < c_NUM_TRIG; i++) begin
                            r_trig_cnt[i] <= 16'd0;
                        end
                        if (CPT_MAX == 16'd0) begin
                            r_state           <= S_WRITE;
                            SCurve_Data       <= FRAME_HEADER;
                            SCurve_Data_wr_en <= 1'b1;
                            r_word_idx        <= c_IDX_PULSE;
                        end else begin
                            r_state <= S_COUNT;
                        end
                    end
                end

                S_COUNT: begin
                    if (w_inject) begin
                        // Close the previous window; same-cycle hits open the new one.
                        for (int i = 0; i < c_NUM_TRIG; i++) begin
                            r_trig_cnt[i] <= r_trig_cnt[i] + 16'(r_hit[i]);
                        end
                        r_hit       <= w_hit_edge;
                        r_pulse_cnt <= r_pulse_cnt + 16'd1;
                        if (w_last_pulse) begin
                            r_state      <= S_TAIL;
                            r_tail_timer <= c_TAIL_LOAD;
                        end
                    end else if (r_pulse_cnt != 16'd0) begin
                        r_hit <= r_hit | w_hit_edge;
                    end
                end

                S_TAIL: begin
                    if (r_tail_timer == '0) begin
                        for (int i = 0; i < c_NUM_TRIG; i++) begin
                            r_trig_cnt[i] <= r_trig_cnt[i] + 16'(r_hit[i] | w_hit_edge[i]);
                        end
                        r_hit             <= '0;
                        r_state           <= S_WRITE;
                        SCurve_Data       <= FRAME_HEADER;
                        SCurve_Data_wr_en <= 1'b1;
                        r_word_idx        <= c_IDX_PULSE;
                    end else begin
                        r_tail_timer <= r_tail_timer - 1'b1;
                        r_hit        <= r_hit | w_hit_edge;
                    end
                end

                S_WRITE: begin
                    if (r_word_idx == c_FRAME_LEN) begin
                        r_state          <= S_DONE;
                        One_Channel_Done <= 1'b1;
                    end else begin
                        SCurve_Data       <= frame_word(r_word_idx, FRAME_HEADER, r_pulse_cnt,
                                                        r_trig_cnt[0], r_trig_cnt[1], r_trig_cnt[2]);
                        SCurve_Data_wr_en <= 1'b1;
                        r_word_idx        <= r_word_idx + 3'd1;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_scurve_channel_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_scurve_channel_counter
// Description : Directed self-checking bench for scurve_channel_counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scurve_channel_counter;

    logic        Clk               = 1'b0;
    logic        reset_n           = 1'b0;
    logic        SCurve_Test_Start = 1'b0;
    logic [15:0] CPT_MAX           = 16'd0;
    logic        CLK_EXT           = 1'b0;
    logic        out_trigger0b     = 1'b1;
    logic        out_trigger1b     = 1'b1;
    logic        out_trigger2b     = 1'b1;
    logic [15:0] SCurve_Data;
    logic        SCurve_Data_wr_en;
    logic        One_Channel_Done;

    int vectors     = 0;
    int miscompares = 0;

    always #5 Clk = ~Clk;

    scurve_channel_counter #(
        .SYNC_STAGES  (2),
        .TAIL_CYCLES  (64),
        .FRAME_HEADER (16'hFF45)
    ) dut (
        .Clk               (Clk),
        .reset_n           (reset_n),
        .SCurve_Test_Start (SCurve_Test_Start),
        .CPT_MAX           (CPT_MAX),
        .CLK_EXT           (CLK_EXT),
        .out_trigger0b     (out_trigger0b),
        .out_trigger1b     (out_trigger1b),
        .out_trigger2b     (out_trigger2b),
        .SCurve_Data       (SCurve_Data),
        .SCurve_Data_wr_en (SCurve_Data_wr_en),
        .One_Channel_Done  (One_Channel_Done)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [15:0] n);
        @(negedge Clk);
        CPT_MAX           = n;
        SCurve_Test_Start = 1'b1;
        @(negedge Clk);
        SCurve_Test_Start = 1'b0;
    endtask

    // One injection; selected triggers fire one cycle after the strobe rises.
    task automatic inject(input logic [2:0] mask);
        @(negedge Clk);
        CLK_EXT = 1'b1;
        @(negedge Clk);
        out_trigger0b = ~mask[0];
        out_trigger1b = ~mask[1];
        out_trigger2b = ~mask[2];
        repeat (2) @(negedge Clk);
        CLK_EXT       = 1'b0;
        out_trigger0b = 1'b1;
        out_trigger1b = 1'b1;
        out_trigger2b = 1'b1;
        repeat (3) @(negedge Clk);
    endtask

    task automatic wait_frame(input string tag, input logic [15:0] p, input logic [15:0] t0,
                              input logic [15:0] t1, input logic [15:0] t2, input int budget);
        int n;
        n = 0;
        while (!SCurve_Data_wr_en && n < budget) begin
            @(negedge Clk);
            n++;
        end
        chk({tag, "/wr_en0"}, 16'(SCurve_Data_wr_en), 16'd1);
        chk({tag, "/hdr"},    SCurve_Data, 16'hFF45);
        @(negedge Clk);
        chk({tag, "/wr_en1"}, 16'(SCurve_Data_wr_en), 16'd1);
        chk({tag, "/pulse"},  SCurve_Data, p);
        @(negedge Clk);
        chk({tag, "/trig0"},  SCurve_Data, t0);
        @(negedge Clk);
        chk({tag, "/trig1"},  SCurve_Data, t1);
        @(negedge Clk);
        chk({tag, "/wr_en4"}, 16'(SCurve_Data_wr_en), 16'd1);
        chk({tag, "/trig2"},  SCurve_Data, t2);
        @(negedge Clk);
        chk({tag, "/done"},   16'(One_Channel_Done), 16'd1);
        chk({tag, "/wr_off"}, 16'(SCurve_Data_wr_en), 16'd0);
        @(negedge Clk);
        chk({tag, "/done_off"}, 16'(One_Channel_Done), 16'd0);
    endtask

    initial begin
        logic seen;

        // Reset state
        repeat (3) @(negedge Clk);
        chk("rst/data",  SCurve_Data, 16'h0000);
        chk("rst/wr_en", 16'(SCurve_Data_wr_en), 16'd0);
        chk("rst/done",  16'(One_Channel_Done), 16'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge Clk);

        // Ten injections, trigger0 on every one
        start(16'd10);
        repeat (10) inject(3'b001);
        wait_frame("t10", 16'd10, 16'd10, 16'd0, 16'd0, 200);

        // Four injections, trigger1 burst inside window 1 and a single hit in window 3
        start(16'd4);
        inject(3'b000);
        repeat (3) begin
            out_trigger1b = 1'b0;
            repeat (2) @(negedge Clk);
            out_trigger1b = 1'b1;
            repeat (2) @(negedge Clk);
        end
        inject(3'b000);
        inject(3'b010);
        inject(3'b000);
        wait_frame("t4", 16'd4, 16'd0, 16'd2, 16'd0, 200);

        // Trigger2 falls 20 cycles after the last strobe: inside the tail
        start(16'd3);
        repeat (3) inject(3'b000);
        repeat (14) @(negedge Clk);
        out_trigger2b = 1'b0;
        repeat (3) @(negedge Clk);
        out_trigger2b = 1'b1;
        wait_frame("tail20", 16'd3, 16'd0, 16'd0, 16'd1, 200);

        // Same, but 100 cycles later: past the tail
        start(16'd3);
        repeat (3) inject(3'b000);
        fork
            begin
                repeat (94) @(negedge Clk);
                out_trigger2b = 1'b0;
                repeat (3) @(negedge Clk);
                out_trigger2b = 1'b1;
            end
            wait_frame("tail100", 16'd3, 16'd0, 16'd0, 16'd0, 200);
        join
        repeat (4) @(negedge Clk);

        // Zero injections: immediate empty frame
        start(16'd0);
        wait_frame("zero", 16'd0, 16'd0, 16'd0, 16'd0, 7);

        // Trigger edge before the first injection is discarded
        start(16'd2);
        repeat (3) @(negedge Clk);
        out_trigger0b = 1'b0;
        repeat (3) @(negedge Clk);
        out_trigger0b = 1'b1;
        repeat (3) @(negedge Clk);
        repeat (2) inject(3'b000);
        wait_frame("prehit", 16'd2, 16'd0, 16'd0, 16'd0, 200);

        // Restart and CPT_MAX change during COUNT are ignored
        start(16'd3);
        inject(3'b000);
        start(16'd7);
        repeat (2) inject(3'b000);
        wait_frame("restart", 16'd3, 16'd0, 16'd0, 16'd0, 200);

        // Reset pulse in TAIL aborts the frame
        start(16'd2);
        repeat (2) inject(3'b001);
        repeat (10) @(negedge Clk);
        reset_n = 1'b0;
        #1;
        chk("abort/data",  SCurve_Data, 16'h0000);
        chk("abort/wr_en", 16'(SCurve_Data_wr_en), 16'd0);
        chk("abort/done",  16'(One_Channel_Done), 16'd0);
        @(negedge Clk);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (100) begin
            @(negedge Clk);
            if (SCurve_Data_wr_en || One_Channel_Done) seen = 1'b1;
        end
        chk("abort/no_frame", 16'(seen), 16'd0);

        // Fresh run after the abort
        start(16'd1);
        inject(3'b111);
        wait_frame("fresh", 16'd1, 16'd1, 16'd1, 16'd1, 200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
